// File: rtl/feedback_pkg.sv
// Shared types and defaults for the feedback LED blinker.
//   blink_state_t  : blinker FSM states
//   DEF_*          : default timing / queue parameters
//   phase_width()  : width of the per-state phase counter
package feedback_pkg;

    typedef enum logic [1:0] {S_IDLE, S_ON, S_GAP} blink_state_t;

    localparam int unsigned DEF_ON_CYCLES   = 4;
    localparam int unsigned DEF_GAP_CYCLES  = 2;
    localparam int unsigned DEF_MAX_PENDING = 7;
    localparam int unsigned DEF_PEND_W      = 3;

    // The phase counter must reach the longer of the two phases; never narrower than 1 bit.
    function automatic int unsigned phase_width(input int unsigned on_c, input int unsigned gap_c);
        int unsigned longest;
        int unsigned w;
        longest = (on_c > gap_c) ? on_c : gap_c;
        w       = $clog2(longest);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/sat_updown_counter.sv
// Saturating up/down counter used as the pending-event queue.
//   Clock, Reset : clock, synchronous active-high reset (count -> 0)
//   inc, dec     : step requests; both together leave count unchanged
//   count        : current value, held within [0, MAX]
//   full         : count == MAX
module sat_updown_counter #(
    parameter int unsigned WIDTH = 3,
    parameter int unsigned MAX   = 7
) (
    input  logic             Clock,
    input  logic             Reset,
    input  logic             inc,
    input  logic             dec,
    output logic [WIDTH-1:0] count,
    output logic             full
);

    localparam logic [WIDTH-1:0] MAX_V = WIDTH'(MAX);

    always_ff @(posedge Clock) begin
        if (Reset) begin
            count <= '0;
        end else if (inc && !dec && (count != MAX_V)) begin
            count <= count + 1'b1;
        end else if (dec && !inc && (count != '0)) begin
            count <= count - 1'b1;
        end
    end

    assign full = (count == MAX_V);

endmodule

// File: rtl/feedback_blinker.sv
// Turns single-cycle event pulses into visible LED blinks: ON_CYCLES high,
// then GAP_CYCLES low. Events arriving mid-blink are queued and replayed.
//   Clock, Reset : clock, synchronous active-high reset
//   pulse        : one event per high cycle
//   led          : high while a blink is on
//   busy         : high whenever not idle
//   pending      : queued events not yet started
//   overflow     : sticky, an event was dropped because the queue was full
module feedback_blinker
    import feedback_pkg::*;
#(
    parameter int unsigned ON_CYCLES   = DEF_ON_CYCLES,
    parameter int unsigned GAP_CYCLES  = DEF_GAP_CYCLES,
    parameter int unsigned MAX_PENDING = DEF_MAX_PENDING,
    parameter int unsigned PEND_W      = DEF_PEND_W
) (
    input  logic              Clock,
    input  logic              Reset,
    input  logic              pulse,
    output logic              led,
    output logic              busy,
    output logic [PEND_W-1:0] pending,
    output logic              overflow
);

    localparam int unsigned     PH_W     = phase_width(ON_CYCLES, GAP_CYCLES);
    localparam logic [PH_W-1:0] ON_LAST  = PH_W'(ON_CYCLES - 1);
    localparam logic [PH_W-1:0] GAP_LAST = PH_W'(GAP_CYCLES - 1);

    blink_state_t    state, state_nx;
    logic [PH_W-1:0] phase, phase_nx;
    logic            q_inc, q_dec, q_full, drop;

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state    <= S_IDLE;
            phase    <= '0;
            overflow <= 1'b0;
        end else begin
            state <= state_nx;
            phase <= phase_nx;
            if (drop) begin
                overflow <= 1'b1;
            end
        end
    end

    always_comb begin
        state_nx = state;
        phase_nx = phase;
        q_inc    = 1'b0;
        q_dec    = 1'b0;
        drop     = 1'b0;
        unique case (state)
            S_IDLE: begin
                if (pulse) begin
                    state_nx = S_ON;
                    phase_nx = '0;
                end
            end
            S_ON: begin
                if (pulse) begin
                    if (q_full) drop  = 1'b1;
                    else        q_inc = 1'b1;
                end
                if (phase == ON_LAST) begin
                    state_nx = S_GAP;
                    phase_nx = '0;
                end else begin
                    phase_nx = phase + 1'b1;
                end
            end
            S_GAP: begin
                if (phase == GAP_LAST) begin
                    // A same-cycle pulse replaces the queued event it would
                    // otherwise consume, so the queue only shrinks without one.
                    if ((pending != '0) || pulse) begin
                        state_nx = S_ON;
                        phase_nx = '0;
                        q_dec    = (pending != '0) && !pulse;
                    end else begin
                        state_nx = S_IDLE;
                        phase_nx = '0;
                    end
                end else begin
                    if (pulse) begin
                        if (q_full) drop  = 1'b1;
                        else        q_inc = 1'b1;
                    end
                    phase_nx = phase + 1'b1;
                end
            end
            default: begin
                state_nx = S_IDLE;
                phase_nx = '0;
            end
        endcase
    end

    sat_updown_counter #(
        .WIDTH (PEND_W),
        .MAX   (MAX_PENDING)
    ) u_pending (
        .Clock (Clock),
        .Reset (Reset),
        .inc   (q_inc),
        .dec   (q_dec),
        .count (pending),
        .full  (q_full)
    );

    assign led  = (state == S_ON);
    assign busy = (state != S_IDLE);

endmodule

// File: tb/tb_feedback_blinker.sv
// Directed bench for feedback_blinker with a countdown-based reference model.
module tb_feedback_blinker;

    localparam int ON   = 4;
    localparam int GAP  = 2;
    localparam int MAXP = 7;

    logic       Clock = 1'b0;
    logic       Reset = 1'b1;
    logic       pulse = 1'b0;
    logic       led, busy, overflow;
    logic [2:0] pending;

    feedback_blinker #(
        .ON_CYCLES   (ON),
        .GAP_CYCLES  (GAP),
        .MAX_PENDING (MAXP),
        .PEND_W      (3)
    ) dut (
        .Clock    (Clock),
        .Reset    (Reset),
        .pulse    (pulse),
        .led      (led),
        .busy     (busy),
        .pending  (pending),
        .overflow (overflow)
    );

    always #5 Clock = ~Clock;

    int checks   = 0;
    int failures = 0;

    // Model: cycles of light left, cycles of gap left, queue depth, sticky drop flag.
    int m_on   = 0;
    int m_gap  = 0;
    int m_pend = 0;
    int m_ovf  = 0;

    int   rises    = 0;
    logic prev_led = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input int exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d at t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic enqueue(input bit p);
        if (p) begin
            if (m_pend < MAXP) m_pend++;
            else               m_ovf = 1;
        end
    endtask

    task automatic model_step(input bit p, input bit r);
        if (r) begin
            m_on = 0; m_gap = 0; m_pend = 0; m_ovf = 0;
        end else if (m_on == 0 && m_gap == 0) begin
            if (p) m_on = ON;
        end else if (m_on > 0) begin
            enqueue(p);
            m_on--;
            if (m_on == 0) m_gap = GAP;
        end else if (m_gap == 1) begin
            m_gap = 0;
            if (m_pend > 0 || p) begin
                m_on = ON;
                if (m_pend > 0 && !p) m_pend--;
            end
        end else begin
            m_gap--;
            enqueue(p);
        end
    endtask

    task automatic step(input bit p, input bit r);
        pulse = p;
        Reset = r;
        @(posedge Clock);
        model_step(p, r);
        @(negedge Clock);
        chk("model_led",      led,      (m_on > 0) ? 1 : 0);
        chk("model_busy",     busy,     (m_on > 0 || m_gap > 0) ? 1 : 0);
        chk("model_pending",  pending,  m_pend);
        chk("model_overflow", overflow, m_ovf);
        if (led && !prev_led) rises++;
        prev_led = led;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((m_on > 0 || m_gap > 0) && n < 200) begin
            step(0, 0);
            n++;
        end
        chk("drain_idle", busy, 0);
    endtask

    initial begin
        int e_led  [8] = '{1, 1, 1, 1, 0, 0, 0, 0};
        int e_busy [8] = '{1, 1, 1, 1, 1, 1, 0, 0};

        // Reset, then idle
        step(0, 1);
        step(0, 1);
        chk("rst_led", led, 0);
        chk("rst_pending", pending, 0);
        for (int i = 0; i < 5; i++) step(0, 0);
        chk("idle_busy", busy, 0);

        // Single pulse: four cycles lit, two gap cycles, then idle
        for (int t = 0; t < 8; t++) begin
            step(t == 0, 0);
            chk("single_led", led, e_led[t]);
            chk("single_busy", busy, e_busy[t]);
        end

        // Pulses at relative cycles 0, 2, 3: three back-to-back blinks
        for (int t = 0; t < 20; t++) begin
            step(t == 0 || t == 2 || t == 3, 0);
            if (t == 3)  chk("triple_pend2", pending, 2);
            if (t == 5)  chk("triple_gap_led", led, 0);
            if (t == 6)  begin chk("triple_pend1", pending, 1); chk("triple_led2", led, 1); end
            if (t == 12) begin chk("triple_pend0", pending, 0); chk("triple_led3", led, 1); end
            if (t == 15) chk("triple_led3_last", led, 1);
            if (t == 16) chk("triple_led3_off", led, 0);
        end
        chk("triple_ovf", overflow, 0);
        drain();

        // Pulse held 12 cycles: queue saturates, overflow sticks
        rises = 0;
        for (int t = 0; t < 12; t++) begin
            step(1, 0);
            if (t == 8) begin chk("burst_pend7", pending, 7); chk("burst_ovf0", overflow, 0); end
            if (t == 9) chk("burst_ovf1", overflow, 1);
        end
        drain();
        chk("burst_blinks", rises, 9);
        chk("burst_pend_end", pending, 0);
        chk("burst_ovf_sticky", overflow, 1);
        step(0, 1);
        chk("burst_ovf_cleared", overflow, 0);

        // Pulse on final gap cycle with empty queue: immediate restart
        for (int t = 0; t < 8; t++) begin
            step(t == 0 || t == 6, 0);
            if (t == 5) chk("fg0_gap_led", led, 0);
            if (t == 6) begin chk("fg0_restart_led", led, 1); chk("fg0_pend", pending, 0); end
        end
        drain();

        // Pulse on final gap cycle with full queue: no change, no overflow
        for (int t = 0; t < 13; t++) begin
            step((t <= 5) || (t >= 7 && t <= 9) || t == 12, 0);
            if (t == 9)  chk("fgfull_pend7", pending, 7);
            if (t == 12) begin
                chk("fgfull_pend_hold", pending, 7);
                chk("fgfull_ovf", overflow, 0);
                chk("fgfull_led", led, 1);
            end
        end
        drain();

        // Reset mid-blink with three queued events; coincident pulse ignored
        for (int t = 0; t < 4; t++) step(1, 0);
        chk("rstmid_pend3", pending, 3);
        step(1, 1);
        chk("rstmid_led", led, 0);
        chk("rstmid_busy", busy, 0);
        chk("rstmid_pend", pending, 0);
        step(0, 0);
        chk("rstmid_after_led", led, 0);
        chk("rstmid_after_busy", busy, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
